capture_trigger_writer: RTL and testbench

//  Stage directly downstream of the capture front-end. Takes one 32ch x 8-sample word per clock,

---
 rtl/capture_trigger_writer_pkg.sv | 43 ++++
 rtl/capture_trigger_writer_trigger_match.sv | 34 +++
 rtl/capture_trigger_writer.sv | 174 +++++++++++++++++
 tb/tb_capture_trigger_writer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_trigger_writer_pkg.sv
// Shared types and helpers for the capture trigger/writer stage.
package capture_trigger_writer_pkg;

  localparam int unsigned CH_N   = 32;
  localparam int unsigned SPW    = 8;
  localparam int unsigned WORD_W = CH_N * SPW;
  localparam int unsigned SLOT_W = 3;

  // Front-end layout: [channel][sample], sample 7 oldest .. 0 newest
  typedef logic [CH_N-1:0][SPW-1:0] sample_word_t;
  // RAM layout: [slot][channel], slot 0 oldest .. 7 newest
  typedef logic [SPW-1:0][CH_N-1:0] slot_word_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4
  } cap_state_t;

  // Channel-major front-end word to slot-major RAM word
  function automatic slot_word_t transpose(input sample_word_t s);
    slot_word_t t;
    for (int k = 0; k < SPW; k++) begin
      for (int c = 0; c < CH_N; c++) begin
        t[k][c] = s[c][SPW-1-k];
      end
    end
    return t;
  endfunction

  // Index of the lowest set bit (earliest slot); 0 when none set
  function automatic logic [SLOT_W-1:0] first_hit(input logic [SPW-1:0] h);
    logic [SLOT_W-1:0] idx;
    idx = '0;
    for (int k = SPW - 1; k >= 0; k--) begin
      if (h[k]) idx = SLOT_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/capture_trigger_writer_trigger_match.sv
// Per-slot level/edge trigger evaluation over all channels of one word.
module trigger_match
  import capture_trigger_writer_pkg::*;
(
  input  slot_word_t        cur,
  input  logic [CH_N-1:0]   prev,
  input  logic [CH_N-1:0]   level_mask,
  input  logic [CH_N-1:0]   edge_mask,
  input  logic [CH_N-1:0]   trig_value,
  output logic [SPW-1:0]    hit_c
);

  // With no channel enabled the AND-reduction would be vacuously true
  logic any_en;
  assign any_en = |(level_mask | edge_mask);

  for (genvar k = 0; k < SPW; k++) begin : g_slot
    logic [CH_N-1:0] prv;
    logic [CH_N-1:0] eq;
    logic [CH_N-1:0] ok;

    // Slot 0 compares against the newest sample of the previous word
    if (k == 0) begin : g_first
      assign prv = prev;
    end else begin : g_rest
      assign prv = cur[k-1];
    end

    assign eq       = ~(cur[k] ^ trig_value);
    assign ok       = (~level_mask | eq) & (~edge_mask | (eq & (prv ^ cur[k])));
    assign hit_c[k] = any_en & (&ok);
  end

endmodule

// File: rtl/capture_trigger_writer.sv
// Trigger evaluation and sample-RAM write sequencing (pre-fill / wait / post).
module capture_trigger_writer
  import capture_trigger_writer_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
)
(
  input  logic                clk,
  input  logic                rst,
  input  sample_word_t        states,
  input  logic                arm,
  input  logic                force_trig,
  input  logic [CH_N-1:0]     level_mask,
  input  logic [CH_N-1:0]     edge_mask,
  input  logic [CH_N-1:0]     trig_value,
  input  logic [ADDR_W-1:0]   pre_words,
  input  logic [ADDR_W-1:0]   post_words,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_data,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   trig_addr,
  output logic [SLOT_W-1:0]   trig_slot,
  output logic [ADDR_W-1:0]   start_addr,
  output logic                wrapped
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  slot_word_t        word_a;
  logic [CH_N-1:0]   prev_a;
  logic              force_a;

  logic [CH_N-1:0]   lvl_q, edg_q, val_q;
  logic [ADDR_W-1:0] pre_q, post_q;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q;
  cap_state_t        state_q, state_d;

  logic [SPW-1:0]    hit_raw_c, hit_c;
  logic              eval_c, trig_c, write_c;

  // Stage A: transposed word, newest samples of the prior word, forced trigger
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_a  <= '0;
      prev_a  <= '0;
      force_a <= 1'b0;
    end else begin
      word_a  <= transpose(states);
      prev_a  <= word_a[SPW-1];
      force_a <= force_trig;
    end
  end

  // Capture configuration, latched on arm
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q  <= '0;
      edg_q  <= '0;
      val_q  <= '0;
      pre_q  <= '0;
      post_q <= '0;
    end else if (arm) begin
      lvl_q  <= level_mask;
      edg_q  <= edge_mask;
      val_q  <= trig_value;
      pre_q  <= pre_words;
      post_q <= post_words;
    end
  end

  trigger_match u_match (
    .cur        (word_a),
    .prev       (prev_a),
    .level_mask (lvl_q),
    .edge_mask  (edg_q),
    .trig_value (val_q),
    .hit_c      (hit_raw_c)
  );

  assign hit_c   = hit_raw_c | SPW'(force_a);
  // PRE hands over to trigger evaluation on the word after the last pre word
  assign eval_c  = (state_q == WAIT_TRIG) || ((state_q == PRE) && (pre_cnt_q == pre_q));
  assign trig_c  = eval_c && (|hit_c);
  assign write_c = (state_q == PRE) || (state_q == WAIT_TRIG) || (state_q == POST);

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
    end
  end

  // Next-state and counter logic; arm overrides everything
  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    case (state_q)
      PRE: begin
        if (!eval_c) begin
          pre_cnt_d = pre_cnt_q + 1'b1;
        end else if (trig_c) begin
          state_d    = (post_q == '0) ? DONE : POST;
          post_cnt_d = '0;
        end else begin
          state_d = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        if (trig_c) begin
          state_d    = (post_q == '0) ? DONE : POST;
          post_cnt_d = '0;
        end
      end
      POST: begin
        post_cnt_d = post_cnt_q + 1'b1;
        if (post_cnt_d == post_q) state_d = DONE;
      end
      default: ;
    endcase
    if (arm) begin
      state_d    = PRE;
      pre_cnt_d  = '0;
      post_cnt_d = '0;
    end
  end

  // Stage B: RAM write port, address/wrap tracking and capture status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      wr_addr_q  <= '0;
      wrapped    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      trig_addr  <= '0;
      trig_slot  <= '0;
      start_addr <= '0;
    end else begin
      mem_we <= write_c;
      busy   <= (state_d != IDLE) && (state_d != DONE);
      done   <= (state_d == DONE);
      if (write_c) begin
        mem_addr <= wr_addr_q;
        mem_data <= word_a;
      end
      if (arm) begin
        wr_addr_q <= '0;
        wrapped   <= 1'b0;
      end else if (write_c) begin
        wr_addr_q <= wr_addr_q + 1'b1;
        if (wr_addr_q == ADDR_MAX) wrapped <= 1'b1;
      end
      if (trig_c && !arm) begin
        trig_addr  <= wr_addr_q;
        trig_slot  <= first_hit(hit_c);
        start_addr <= wr_addr_q - pre_q;
      end
    end
  end

endmodule

// File: tb/tb_capture_trigger_writer.sv
// Scoreboard bench for capture_trigger_writer (16-word RAM).
module tb_capture_trigger_writer;
  import capture_trigger_writer_pkg::*;

  localparam int unsigned ADDR_W = 4;

  typedef logic [SPW-1:0][CH_N-1:0] slots_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } exp_t;

  logic                clk;
  logic                rst;
  sample_word_t        states;
  logic                arm;
  logic                force_trig;
  logic [CH_N-1:0]     level_mask;
  logic [CH_N-1:0]     edge_mask;
  logic [CH_N-1:0]     trig_value;
  logic [ADDR_W-1:0]   pre_words;
  logic [ADDR_W-1:0]   post_words;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [WORD_W-1:0]   mem_data;
  logic                busy;
  logic                done;
  logic [ADDR_W-1:0]   trig_addr;
  logic [SLOT_W-1:0]   trig_slot;
  logic [ADDR_W-1:0]   start_addr;
  logic                wrapped;

  exp_t exp_q[$];
  exp_t got;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] b;

  capture_trigger_writer #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .states     (states),
    .arm        (arm),
    .force_trig (force_trig),
    .level_mask (level_mask),
    .edge_mask  (edge_mask),
    .trig_value (trig_value),
    .pre_words  (pre_words),
    .post_words (post_words),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .busy       (busy),
    .done       (done),
    .trig_addr  (trig_addr),
    .trig_slot  (trig_slot),
    .start_addr (start_addr),
    .wrapped    (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Slot-major stimulus to the front-end channel-major layout
  function automatic sample_word_t to_states(input slots_t s);
    sample_word_t st;
    for (int c = 0; c < CH_N; c++) begin
      for (int k = 0; k < SPW; k++) begin
        st[c][SPW-1-k] = s[k][c];
      end
    end
    return st;
  endfunction

  // Random word with channel ch forced to bits (bit k = slot k)
  function automatic slots_t rnd_word(input int ch, input logic [7:0] bits);
    slots_t s;
    for (int k = 0; k < SPW; k++) begin
      s[k]     = $urandom;
      s[k][ch] = bits[k];
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic cfg(input int pre, input int post, input logic [31:0] lvl,
                     input logic [31:0] edg, input logic [31:0] val);
    pre_words  = ADDR_W'(pre);
    post_words = ADDR_W'(post);
    level_mask = lvl;
    edge_mask  = edg;
    trig_value = val;
  endtask

  // Present one word; if it must be written, queue the expected RAM write
  task automatic send(input slots_t s, input bit we, input int addr);
    exp_t e;
    states = to_states(s);
    if (we) begin
      e.addr = ADDR_W'(addr);
      e.data = s;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send('0, 1'b0, 0);
  endtask

  task automatic status(input string tag, input logic [31:0] e_done, input logic [31:0] e_ta,
                        input logic [31:0] e_ts, input logic [31:0] e_sa, input logic [31:0] e_wr);
    chk({tag, "_done"}, 32'(done), e_done);
    chk({tag, "_busy"}, 32'(busy), 32'(!e_done[0]));
    chk({tag, "_trig_addr"}, 32'(trig_addr), e_ta);
    chk({tag, "_trig_slot"}, 32'(trig_slot), e_ts);
    chk({tag, "_start_addr"}, 32'(start_addr), e_sa);
    chk({tag, "_wrapped"}, 32'(wrapped), e_wr);
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every RAM write must match the next queued expectation
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d", mem_addr);
      end else begin
        got = exp_q.pop_front();
        if (mem_addr !== got.addr || mem_data !== got.data) begin
          errors++;
          $display("FAIL write addr act=%0d exp=%0d data act=%h exp=%h",
                   mem_addr, got.addr, mem_data, got.data);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; arm = 1'b0; force_trig = 1'b0; states = '0;
    cfg(0, 0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_data", 32'(|mem_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wrapped", 32'(wrapped), 0);
    chk("rst_trig_addr", 32'(trig_addr), 0);
    rst = 1'b0;
    idle(3);
    chk("idle_busy", 32'(busy), 0);

    // Level trigger on ch0 at word 6 slot 5, pre 4 / post 3
    cfg(4, 3, 32'h1, 32'h0, 32'h1);
    arm = 1'b1;
    send(rnd_word(0, 8'h00), 1'b1, 0);
    arm = 1'b0;
    for (int w = 1; w <= 5; w++) send(rnd_word(0, 8'h00), 1'b1, w);
    chk("lvl_busy_mid", 32'(busy), 1);
    send(rnd_word(0, 8'hE0), 1'b1, 6);
    for (int w = 7; w <= 9; w++) send(rnd_word(0, 8'hFF), 1'b1, w);
    idle(2);
    status("lvl", 1, 6, 5, 2, 0);

    // Edge on ch3 across a word boundary, pre 0 / post 0
    cfg(0, 0, 32'h0, 32'h8, 32'h8);
    arm = 1'b1;
    send(rnd_word(3, 8'h00), 1'b1, 0);
    arm = 1'b0;
    send(rnd_word(3, 8'hFF), 1'b1, 1);
    idle(2);
    status("edge", 1, 1, 0, 1, 0);

    // ch3 held high: no edge; force_trig ends the wait
    cfg(0, 2, 32'h0, 32'h8, 32'h8);
    send(rnd_word(3, 8'hFF), 1'b0, 0);
    arm = 1'b1;
    send(rnd_word(3, 8'hFF), 1'b1, 0);
    arm = 1'b0;
    send(rnd_word(3, 8'hFF), 1'b1, 1);
    send(rnd_word(3, 8'hFF), 1'b1, 2);
    chk("held_busy", 32'(busy), 1);
    chk("held_done", 32'(done), 0);
    force_trig = 1'b1;
    send(rnd_word(3, 8'hFF), 1'b1, 3);
    force_trig = 1'b0;
    send(rnd_word(3, 8'hFF), 1'b1, 4);
    send(rnd_word(3, 8'hFF), 1'b1, 5);
    idle(2);
    status("force", 1, 3, 0, 3, 0);

    // Hits on slots 2 and 6 of one word; pre-word hit ignored
    cfg(1, 1, 32'h80, 32'h0, 32'h80);
    arm = 1'b1;
    send(rnd_word(7, 8'h02), 1'b1, 0);
    arm = 1'b0;
    send(rnd_word(7, 8'h44), 1'b1, 1);
    send(rnd_word(7, 8'h00), 1'b1, 2);
    idle(2);
    status("multi", 1, 1, 2, 0, 0);

    // Address wrap: pre 12, post 10, trigger at word 18 slot 3
    cfg(12, 10, 32'h1, 32'h0, 32'h1);
    arm = 1'b1;
    for (int w = 0; w <= 28; w++) begin
      b = (w < 18) ? 8'h00 : ((w == 18) ? 8'hF8 : 8'hFF);
      send(rnd_word(0, b), 1'b1, w & 15);
      arm = 1'b0;
    end
    idle(2);
    status("wrap", 1, 2, 3, 6, 1);

    // Re-arm during POST after a wrap
    cfg(14, 6, 32'h1, 32'h0, 32'h1);
    arm = 1'b1;
    for (int w = 0; w <= 17; w++) begin
      send(rnd_word(0, (w < 14) ? 8'h00 : 8'hFF), 1'b1, w & 15);
      arm = 1'b0;
    end
    chk("rearm_pre_wrapped", 32'(wrapped), 1);
    chk("rearm_pre_done", 32'(done), 0);
    cfg(1, 1, 32'h1, 32'h0, 32'h1);
    arm = 1'b1;
    send(rnd_word(0, 8'hFF), 1'b1, 0);
    arm = 1'b0;
    chk("rearm_wrapped_clr", 32'(wrapped), 0);
    chk("rearm_busy", 32'(busy), 1);
    send(rnd_word(0, 8'hFF), 1'b1, 1);
    send(rnd_word(0, 8'hFF), 1'b1, 2);
    idle(2);
    status("rearm", 1, 1, 0, 0, 0);

    // Asynchronous reset in the middle of POST
    cfg(0, 5, 32'h1, 32'h0, 32'h1);
    arm = 1'b1;
    send(rnd_word(0, 8'hFF), 1'b1, 0);
    arm = 1'b0;
    send(rnd_word(0, 8'hFF), 1'b1, 1);
    send(rnd_word(0, 8'hFF), 1'b1, 2);
    chk("post_busy", 32'(busy), 1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_mem_we", 32'(mem_we), 0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 0);
    chk("mid_rst_mem_data", 32'(|mem_data), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_trig_addr", 32'(trig_addr), 0);
    chk("mid_rst_start_addr", 32'(start_addr), 0);
    exp_q.delete();
    #1;
    rst = 1'b0;
    idle(3);
    chk("after_rst_busy", 32'(busy), 0);
    chk("after_rst_mem_we", 32'(mem_we), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
